// File: rtl/fix_initiator_engine.sv
// Byte-serial FIX session front-end: latches session config, opens a session on start,
// forwards inbound bytes with a one-cycle valid pulse, and closes on heartbeat inactivity.
module fix_initiator_engine #(
   parameter int         HB_SHIFT = 4,
   parameter logic [7:0] EOM_BYTE = 8'h3B
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         start,
   input  logic         configure,
   input  logic [7:0]   din,
   input  logic [1:0]   connectType,
   input  logic [7:0]   reconnectInt,
   input  logic [15:0]  starttime,
   input  logic [15:0]  endtime,
   input  logic [5:0]   beginstring,
   input  logic [5:0]   defaultApplVerId,
   input  logic [255:0] senderCompId,
   input  logic [255:0] targetCompId,
   input  logic [15:0]  hostAddr,
   input  logic [7:0]   heartBeatInt,
   output logic [7:0]   dout,
   output logic         valid
);

   localparam int WDW = 8 + HB_SHIFT;

   typedef enum logic [1:0] {UNCONFIG, CONFIGURED, SESSION} state_t;

   state_t         state;
   logic [1:0]     cfg_ct;
   logic [7:0]     cfg_reconnect;
   logic [15:0]    cfg_start;
   logic [15:0]    cfg_end;
   logic [5:0]     cfg_begin;
   logic [5:0]     cfg_appl;
   logic [255:0]   cfg_sender;
   logic [255:0]   cfg_target;
   logic [15:0]    cfg_host;
   logic [7:0]     cfg_hb;
   logic [WDW-1:0] wd;
   logic           eom;

   logic [WDW-1:0] timeout;
   logic [WDW-1:0] wd_inc;
   logic           ct_ok;

   assign timeout = WDW'(cfg_hb) << HB_SHIFT;
   assign wd_inc  = (wd == '1) ? wd : wd + WDW'(1);
   assign ct_ok   = (cfg_ct == 2'b01) || (cfg_ct == 2'b10);

   // Stored-only configuration has no consumer inside this block.
   logic unused_cfg;
   assign unused_cfg = ^{cfg_reconnect, cfg_start, cfg_end, cfg_begin, cfg_appl,
                         cfg_sender, cfg_target, cfg_host, eom};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= UNCONFIG;
         dout          <= 8'h00;
         valid         <= 1'b0;
         cfg_ct        <= '0;
         cfg_reconnect <= '0;
         cfg_start     <= '0;
         cfg_end       <= '0;
         cfg_begin     <= '0;
         cfg_appl      <= '0;
         cfg_sender    <= '0;
         cfg_target    <= '0;
         cfg_host      <= '0;
         cfg_hb        <= '0;
         wd            <= '0;
         eom           <= 1'b0;
      end else begin
         valid <= 1'b0;
         dout  <= 8'h00;
         if (configure) begin
            // Configure wins over start and enable; any same-cycle byte is dropped.
            cfg_ct        <= connectType;
            cfg_reconnect <= reconnectInt;
            cfg_start     <= starttime;
            cfg_end       <= endtime;
            cfg_begin     <= beginstring;
            cfg_appl      <= defaultApplVerId;
            cfg_sender    <= senderCompId;
            cfg_target    <= targetCompId;
            cfg_host      <= hostAddr;
            cfg_hb        <= heartBeatInt;
            wd            <= '0;
            state         <= CONFIGURED;
         end else begin
            case (state)
               UNCONFIG: ;
               CONFIGURED: begin
                  if (start && ct_ok) begin
                     state <= SESSION;
                     wd    <= '0;
                  end
               end
               SESSION: begin
                  if (enable) begin
                     dout  <= din;
                     valid <= 1'b1;
                     wd    <= '0;
                     eom   <= (din == EOM_BYTE);
                  end else begin
                     wd <= wd_inc;
                     if ((cfg_hb != 8'h00) && (wd_inc >= timeout))
                        state <= CONFIGURED;
                  end
               end
               default: state <= UNCONFIG;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fix_initiator_engine.sv
// Directed bench for fix_initiator_engine: gating, forwarding, watchdog, collisions, reset.
module tb_fix_initiator_engine;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         enable = 1'b0;
   logic         start = 1'b0;
   logic         configure = 1'b0;
   logic [7:0]   din = 8'h00;
   logic [1:0]   connectType = 2'b00;
   logic [7:0]   reconnectInt = 8'd30;
   logic [15:0]  starttime = 16'h0900;
   logic [15:0]  endtime = 16'h1700;
   logic [5:0]   beginstring = 6'd44;
   logic [5:0]   defaultApplVerId = 6'd9;
   logic [255:0] senderCompId = 256'h53454E444552;
   logic [255:0] targetCompId = 256'h544152474554;
   logic [15:0]  hostAddr = 16'hC0A8;
   logic [7:0]   heartBeatInt = 8'h00;
   logic [7:0]   dout;
   logic         valid;

   int total = 0;
   int passed = 0;

   fix_initiator_engine dut (
      .clk(clk), .reset(reset), .enable(enable), .start(start), .configure(configure),
      .din(din), .connectType(connectType), .reconnectInt(reconnectInt),
      .starttime(starttime), .endtime(endtime), .beginstring(beginstring),
      .defaultApplVerId(defaultApplVerId), .senderCompId(senderCompId),
      .targetCompId(targetCompId), .hostAddr(hostAddr), .heartBeatInt(heartBeatInt),
      .dout(dout), .valid(valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed {valid,dout}=%h expected %h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drive one byte for one cycle, then check the registered output.
   task automatic send(input string tag, input logic [7:0] b, input logic exp_v);
      enable = 1'b1;
      din    = b;
      cyc();
      enable = 1'b0;
      din    = 8'h00;
      chk(tag, {valid, dout}, exp_v ? {1'b1, b} : 9'h000);
   endtask

   task automatic idle(input string tag);
      cyc();
      chk(tag, {valid, dout}, 9'h000);
   endtask

   task automatic do_cfg(input logic [1:0] ct, input logic [7:0] hb);
      connectType  = ct;
      heartBeatInt = hb;
      configure    = 1'b1;
      cyc();
      configure    = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   logic [7:0] msg [6] = '{8'h38, 8'h3D, 8'h46, 8'h49, 8'h58, 8'h3B};

   initial begin
      // Reset holds outputs low even with a live byte strobe.
      din = 8'hFF;
      enable = 1'b1;
      cyc();
      chk("reset_c1", {valid, dout}, 9'h000);
      cyc();
      chk("reset_c2", {valid, dout}, 9'h000);
      enable = 1'b0;
      din = 8'h00;
      #2 reset = 1'b1;
      cyc();

      send("gate_unconfig", 8'h41, 1'b0);
      do_cfg(2'b01, 8'h1E);
      send("gate_noStart", 8'h41, 1'b0);

      do_start();
      for (int i = 0; i < 6; i++) begin
         send($sformatf("fwd_%0d", i), msg[i], 1'b1);
         idle($sformatf("gap_%0d", i));
      end
      // Back-to-back bytes give back-to-back pulses.
      send("b2b_0", 8'h11, 1'b1);
      send("b2b_1", 8'h22, 1'b1);

      // Configure with a byte in the same cycle: byte dropped, session closed.
      configure = 1'b1;
      enable = 1'b1;
      din = 8'h55;
      cyc();
      configure = 1'b0;
      enable = 1'b0;
      din = 8'h00;
      chk("coll_cfg_byte", {valid, dout}, 9'h000);
      send("coll_closed", 8'h66, 1'b0);

      // Start together with configure stays configured.
      start = 1'b1;
      configure = 1'b1;
      cyc();
      start = 1'b0;
      configure = 1'b0;
      send("coll_start_cfg", 8'h77, 1'b0);
      do_start();
      send("restart_ok", 8'h78, 1'b1);

      do_cfg(2'b11, 8'h1E);
      do_start();
      send("gate_badCt", 8'h41, 1'b0);

      // Watchdog with timeout 16: 15 idle cycles survive, 16 close the session.
      do_cfg(2'b10, 8'h01);
      do_start();
      for (int i = 0; i < 15; i++) cyc();
      send("wd_15idle", 8'h42, 1'b1);
      for (int i = 0; i < 16; i++) cyc();
      send("wd_16idle", 8'h41, 1'b0);
      do_start();
      send("wd_restart", 8'h41, 1'b1);

      // Reset between bytes clears outputs without waiting for a clock edge.
      enable = 1'b1;
      din = 8'h10;
      cyc();
      enable = 1'b0;
      din = 8'h00;
      chk("rst_pre", {valid, dout}, 9'h110);
      #2 reset = 1'b0;
      #1 chk("rst_async", {valid, dout}, 9'h000);
      #2 reset = 1'b1;
      cyc();
      send("rst_after", 8'h20, 1'b0);
      do_start();
      send("rst_startOnly", 8'h21, 1'b0);
      do_cfg(2'b01, 8'h1E);
      do_start();
      send("rst_recfg", 8'h22, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fix_initiator_engine.md
Name: fix_initiator_engine

Overview:
- Byte-serial FIX session front-end.
- Holds a session configuration (role, timers, version, comp IDs, host address), loaded by a one-cycle configure strobe.
- A start strobe opens a session. While the session is open, every inbound byte from the counterparty is forwarded to the session output stream with a valid strobe.
- An inactivity (heartbeat) watchdog closes the session.
- Sits between the line-side byte receiver and the downstream FIX message processor.

Parameters:
- HB_SHIFT, 4, log2 of the watchdog multiplier. Timeout in cycles = heartBeatInt << HB_SHIFT.
- EOM_BYTE, 8'h3B, end-of-message delimiter byte.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  inbound byte strobe; din is valid this cycle.
- reset polarity/synchronicity: asynchronous, active-low (fixed).
- start  in  1  one-cycle session-open request.
- configure  in  1  one-cycle configuration load strobe.
- din  in  8  inbound byte.
- connectType  in  2  01 = initiator, 10 = acceptor, others = invalid.
- reconnectInt  in  8  reconnect interval in seconds; stored only.
- starttime  in  16  session start time; stored only.
- endtime  in  16  session end time; stored only.
- beginstring  in  6  FIX BeginString code; stored only.
- defaultApplVerId  in  6  application version code; stored only.
- senderCompId  in  256  ASCII SenderCompID; stored only.
- targetCompId  in  256  ASCII TargetCompID; stored only.
- hostAddr  in  16  host address; stored only.
- heartBeatInt  in  8  heartbeat interval; base of the watchdog.
- dout  out  8  outbound byte.
- valid  out  1  dout valid strobe.

Behaviour:
- Reset (reset=0, asynchronous):
  - dout=8'h00, valid=0, all configuration registers 0, state=UNCONFIG, watchdog=0, eom flag=0.
  - dout must read 8'h00 on every clock while reset is asserted.
  - Reset asserted mid-session aborts the session immediately; no further valid pulses until reconfigured and restarted.
- States:
  - UNCONFIG:
    - configure=1 -> latch all 10 config inputs on this edge; go to CONFIGURED.
    - start and enable are ignored.
  - CONFIGURED:
    - configure=1 -> re-latch config; stay.
    - start=1 with latched connectType in {01,10} -> SESSION; clear watchdog.
    - start with any other connectType is ignored.
    - enable bytes are dropped; valid stays 0.
  - SESSION:
    - enable=1 -> on that edge register dout<=din and valid<=1; clear watchdog.
    - Cycle with enable=0 -> valid<=0, dout<=8'h00, watchdog+1 (saturating).
    - configure=1 -> re-latch config, go to CONFIGURED, valid<=0. A byte arriving in the same cycle is dropped.
    - Watchdog: if heartBeatInt!=0 and watchdog reaches (heartBeatInt<<HB_SHIFT) -> CONFIGURED. heartBeatInt=0 disables the watchdog.
- Priority in one cycle: reset > configure > start > enable.
- Forwarding rules:
  - Latency is exactly 1 cycle from the sampled enable to valid.
  - valid is a one-cycle pulse per byte. Back-to-back enables give back-to-back valid pulses, in order.
  - No byte is dropped, reordered or modified while in SESSION.
  - dout=8'h00 whenever valid=0.
- Message tracking: a byte equal to EOM_BYTE is forwarded normally and sets an internal end-of-message flag. The flag clears on the next forwarded byte. Bytes after EOM_BYTE continue the stream; there is no framing stall.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan:
1. Reset check: hold reset=0 for 2 clocks with din=8'hFF, enable=1 -> dout=8'h00, valid=0 each cycle.
2. Configure and start:
   - Stimulus: configure with connectType=01, heartBeatInt=8'h1E; start; send bytes 38,3D,46,49,58,3B with idle gaps.
   - Required: valid pulses exactly once per byte, 1 cycle after each enable, with dout = 38,3D,46,49,58,3B in order.
3. Gating:
   - Before configure: enable with din=8'h41 -> no valid.
   - After configure but before start: enable with din=8'h41 -> no valid.
   - connectType=11 followed by start -> no valid on subsequent bytes.
4. Watchdog:
   - heartBeatInt=8'h01 (timeout 16 cycles); start; idle 16 cycles; then send 8'h41 -> no valid (session closed).
   - Restart, then send 8'h41 -> valid with dout=8'h41.
5. Collisions:
   - configure and enable in the same cycle during SESSION -> byte dropped, state CONFIGURED.
   - start and configure together in CONFIGURED -> stays CONFIGURED.
6. Reset mid-session: assert reset between two bytes -> valid=0 and dout=00 immediately (asynchronous). After release, bytes are ignored until configure+start.
